// File: rtl/stack_ctrl.sv
// Byte-wide LIFO controller driving an external synchronous RAM.
// Pushes complete in one cycle; pops wait one cycle for the registered RAM read.
module stack_ctrl #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  input  logic       clear_err,
  output logic       ready,
  output logic [7:0] pop_data,
  output logic       pop_valid,
  output logic [6:0] depth,
  output logic       full,
  output logic       empty,
  output logic       err_ovf,
  output logic       err_unf,
  output logic       err_col,
  output logic [5:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_write,
  input  logic [7:0] mem_dout
);

  localparam int unsigned SPW = 7;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 8;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t         state, state_nxt;
  logic [SPW-1:0] sp, sp_nxt;
  logic           is_full, is_empty;
  logic           pv_nxt, load_pd;
  logic           ev_ovf, ev_unf, ev_col;

  assign is_full  = (sp == SPW'(DEPTH));
  assign is_empty = (sp == '0);
  assign full     = is_full;
  assign empty    = is_empty;
  assign depth    = sp;
  assign ready    = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sp    <= '0;
    end else begin
      state <= state_nxt;
      sp    <= sp_nxt;
    end
  end

  // Flush overrides everything; errors are only raised by operations actually attempted.
  always_comb begin
    state_nxt = state;
    sp_nxt    = sp;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    pv_nxt    = 1'b0;
    load_pd   = 1'b0;
    ev_ovf    = 1'b0;
    ev_unf    = 1'b0;
    ev_col    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      sp_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (push && pop) begin
            ev_col = 1'b1;
          end else if (push) begin
            if (is_full) begin
              ev_ovf = 1'b1;
            end else begin
              mem_write = 1'b1;
              mem_addr  = AW'(sp);
              mem_din   = push_data;
              sp_nxt    = sp + SPW'(1);
            end
          end else if (pop) begin
            if (is_empty) begin
              ev_unf = 1'b1;
            end else begin
              mem_addr  = AW'(sp - SPW'(1));
              sp_nxt    = sp - SPW'(1);
              state_nxt = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          state_nxt = IDLE;
          pv_nxt    = 1'b1;
          load_pd   = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pv_nxt;
      if (load_pd) pop_data <= DW'(mem_dout);
    end
  end

  // Sticky flags: a same-cycle event beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_col <= 1'b0;
    end else begin
      err_ovf <= (err_ovf & ~clear_err) | ev_ovf;
      err_unf <= (err_unf & ~clear_err) | ev_unf;
      err_col <= (err_col & ~clear_err) | ev_col;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: directed vector table, corner sequences, and
// randomized traffic checked against a queue-based stack model.
module tb_stack_ctrl;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop, flush, clear_err;
  logic [7:0] push_data;
  logic       ready, pop_valid, full, empty, err_ovf, err_unf, err_col, mem_write;
  logic [7:0] pop_data, mem_din, mem_dout;
  logic [6:0] depth;
  logic [5:0] mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .flush(flush), .clear_err(clear_err), .ready(ready), .pop_data(pop_data),
    .pop_valid(pop_valid), .depth(depth), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_col(err_col),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write), .mem_dout(mem_dout)
  );

  // Synchronous RAM: read data registered one cycle after a non-write address.
  logic [7:0] ram [64];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_din;
    else           mem_dout <= ram[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pu, input logic po, input logic fl, input logic cl,
                       input logic [7:0] d);
    push = pu; pop = po; flush = fl; clear_err = cl; push_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       pu, po, fl, cl;
    logic [7:0] d;
    logic       wr;
    logic [5:0] a;
    logic [7:0] di;
    logic       rdy;
    logic [6:0] dep;
    logic       pv;
    logic [7:0] pd;
    logic [2:0] err;  // {ovf, unf, col}
  } vec_t;

  function automatic vec_t v(input logic pu, input logic po, input logic fl, input logic cl,
                             input logic [7:0] d, input logic wr, input logic [5:0] a,
                             input logic [7:0] di, input logic rdy, input logic [6:0] dep,
                             input logic pv, input logic [7:0] pd, input logic [2:0] err);
    vec_t r;
    r.pu = pu; r.po = po; r.fl = fl; r.cl = cl; r.d = d; r.wr = wr; r.a = a; r.di = di;
    r.rdy = rdy; r.dep = dep; r.pv = pv; r.pd = pd; r.err = err;
    return r;
  endfunction

  // Reference model state
  logic [7:0] stk[$];
  bit         m_wait, m_pv;
  logic [7:0] m_pend, m_pd;
  logic [2:0] m_err;

  vec_t tbl[14];

  initial begin
    // Expected values are the outputs observed during the cycle the inputs are applied.
    tbl[0]  = v(1'b1,1'b0,1'b0,1'b0,8'h11, 1'b1,6'd0,8'h11, 1'b1,7'd0, 1'b0,8'h00,3'b000);
    tbl[1]  = v(1'b1,1'b0,1'b0,1'b0,8'h22, 1'b1,6'd1,8'h22, 1'b1,7'd1, 1'b0,8'h00,3'b000);
    tbl[2]  = v(1'b1,1'b0,1'b0,1'b0,8'h33, 1'b1,6'd2,8'h33, 1'b1,7'd2, 1'b0,8'h00,3'b000);
    tbl[3]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,6'd2,8'h00, 1'b1,7'd3, 1'b0,8'h00,3'b000);
    tbl[4]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,6'd0,8'h00, 1'b0,7'd2, 1'b0,8'h00,3'b000);
    tbl[5]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,6'd1,8'h00, 1'b1,7'd2, 1'b1,8'h33,3'b000);
    tbl[6]  = v(1'b1,1'b1,1'b0,1'b0,8'h55, 1'b0,6'd0,8'h00, 1'b0,7'd1, 1'b0,8'h33,3'b000);
    tbl[7]  = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,6'd0,8'h00, 1'b1,7'd1, 1'b1,8'h22,3'b000);
    tbl[8]  = v(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,6'd0,8'h00, 1'b0,7'd0, 1'b0,8'h22,3'b000);
    tbl[9]  = v(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,6'd0,8'h00, 1'b1,7'd0, 1'b1,8'h11,3'b000);
    tbl[10] = v(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,6'd0,8'h00, 1'b1,7'd0, 1'b0,8'h11,3'b000);
    tbl[11] = v(1'b1,1'b0,1'b0,1'b0,8'h44, 1'b1,6'd0,8'h44, 1'b1,7'd0, 1'b0,8'h11,3'b010);
    tbl[12] = v(1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,6'd0,8'h00, 1'b1,7'd1, 1'b0,8'h11,3'b010);
    tbl[13] = v(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,6'd0,8'h00, 1'b1,7'd1, 1'b0,8'h11,3'b000);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #3;
    chk("rst_depth", depth, 0);      chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);        chk("rst_ready", ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_errs", {err_ovf, err_unf, err_col}, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_pop_data", pop_data, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].pu, tbl[i].po, tbl[i].fl, tbl[i].cl, tbl[i].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_write", i), mem_write, tbl[i].wr);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].a);
      chk($sformatf("tbl%0d_mem_din", i), mem_din, tbl[i].di);
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_depth", i), depth, tbl[i].dep);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].dep == 7'd0);
      chk($sformatf("tbl%0d_full", i), full, 0);
      chk($sformatf("tbl%0d_pop_valid", i), pop_valid, tbl[i].pv);
      chk($sformatf("tbl%0d_pop_data", i), pop_data, tbl[i].pd);
      chk($sformatf("tbl%0d_errs", i), {err_ovf, err_unf, err_col}, tbl[i].err);
      tick();
    end

    // Collision at depth 5
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h50 + 8'(i)); tick(); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    @(negedge clk);
    chk("col_depth_before", depth, 5);
    chk("col_mem_write", mem_write, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("col_depth", depth, 5);  chk("col_err", err_col, 1);
    chk("col_ready", ready, 1);  chk("col_pv0", pop_valid, 0);
    tick();
    @(negedge clk); chk("col_pv1", pop_valid, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); tick();

    // Flush while a pop is pending
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hC0 + 8'(i)); tick(); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk); chk("fl_pop_addr", mem_addr, 2);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("fl_ready_rdwait", ready, 0); chk("fl_mem_write", mem_write, 0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
    @(negedge clk);
    chk("fl_pv", pop_valid, 0);   chk("fl_depth", depth, 0);
    chk("fl_ready", ready, 1);    chk("fl_pop_data_kept", pop_data, 8'h11);
    chk("fl_push_write", mem_write, 1); chk("fl_push_addr", mem_addr, 0);
    tick();

    // Fill to capacity, overflow, clear race
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    for (int i = 0; i < DEPTH; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(i)); tick(); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    @(negedge clk);
    chk("ovf_full", full, 1); chk("ovf_empty", empty, 0); chk("ovf_mem_write", mem_write, 0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
    @(negedge clk);
    chk("ovf_depth", depth, DEPTH); chk("ovf_err", err_ovf, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge clk); chk("ovf_event_beats_clear", err_ovf, 1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf_cleared", err_ovf, 0); chk("top_pop_addr", mem_addr, 63);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    @(negedge clk);
    chk("top_pv", pop_valid, 1); chk("top_pd", pop_data, 8'd63);

    // Reset while a pop is pending
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("rrst_ready", ready, 1);      chk("rrst_depth", depth, 0);
    chk("rrst_pd", pop_data, 0);      chk("rrst_pv", pop_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    @(negedge clk); chk("rrst_pv_after0", pop_valid, 0);
    tick();
    @(negedge clk); chk("rrst_pv_after1", pop_valid, 0);
    tick();

    // Randomized traffic against the stack model
    stk.delete(); m_wait = 0; m_pv = 0; m_pend = 8'h00; m_pd = 8'h00; m_err = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      int ph, ppush, ppop;
      logic       ewr;
      logic [5:0] ea;
      logic [7:0] ed;
      logic [2:0] ev;
      bit         act;
      ph = (i / 400) % 3;
      ppush = (ph == 0) ? 80 : (ph == 1) ? 15 : 45;
      ppop  = (ph == 0) ? 10 : (ph == 1) ? 75 : 45;
      drive(1'($urandom_range(99) < ppush), 1'($urandom_range(99) < ppop),
            1'($urandom_range(199) == 0), 1'($urandom_range(15) == 0), 8'($urandom));
      @(negedge clk);
      act = !flush && !m_wait;
      ewr = 1'b0; ea = 6'd0; ed = 8'h00;
      if (act && push && !pop && stk.size() < DEPTH) begin
        ewr = 1'b1; ea = 6'(stk.size()); ed = push_data;
      end else if (act && pop && !push && stk.size() > 0) begin
        ea = 6'(stk.size() - 1);
      end
      chk("rnd_mem_write", mem_write, ewr);
      chk("rnd_mem_addr", mem_addr, ea);
      chk("rnd_mem_din", mem_din, ed);
      chk("rnd_ready", ready, !m_wait);
      chk("rnd_depth", depth, stk.size());
      chk("rnd_full", full, stk.size() == DEPTH);
      chk("rnd_empty", empty, stk.size() == 0);
      chk("rnd_pop_valid", pop_valid, m_pv);
      chk("rnd_pop_data", pop_data, m_pd);
      chk("rnd_errs", {err_ovf, err_unf, err_col}, m_err);
      ev = {act && push && !pop && stk.size() == DEPTH,
            act && pop && !push && stk.size() == 0,
            act && push && pop};
      m_err = (m_err & {3{!clear_err}}) | ev;
      if (flush) begin
        stk.delete(); m_wait = 0; m_pv = 0;
      end else if (m_wait) begin
        m_pv = 1; m_pd = m_pend; m_wait = 0;
      end else begin
        m_pv = 0;
        if (push && !pop && stk.size() < DEPTH) stk.push_back(push_data);
        else if (pop && !push && stk.size() > 0) begin
          m_pend = stk.pop_back(); m_wait = 1;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, is the stack capacity in bytes; the legal range is 2..64.
REQ-002 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 push  input  1  requests a push of push_data; it is sampled only when ready=1.
REQ-005 push_data  input  8  is the byte to push.
REQ-006 pop  input  1  requests a pop; it is sampled only when ready=1.
REQ-007 flush  input  1  empties the stack; it is sampled every cycle.
REQ-008 clear_err  input  1  clears all sticky error flags.
REQ-009 ready  output  1  is high when the block accepts push/pop.
REQ-010 pop_data  output  8  is registered popped byte, valid when pop_valid=1.
REQ-011 pop_valid  output  1  is a one-cycle pulse that qualifies pop_data.
REQ-012 depth  output  7  is the current occupancy (sp).
REQ-013 full / empty  output  1 each  are depth==DEPTH and depth==0 respectively.
REQ-014 err_ovf / err_unf / err_col  output  1 each  are sticky flags for overflow, underflow and push/pop collision.
REQ-015 mem_addr  output  6  drives the RAM address port.
REQ-016 mem_din  output  8  drives the RAM write data.
REQ-017 mem_write  output  1  is the RAM write strobe.
REQ-018 mem_dout  input  8  is the RAM read data, registered in the RAM one cycle after its address is presented with mem_write=0.

Function
REQ-019 The FSM SHALL have two states: IDLE and RD_WAIT; ready=1 only in IDLE.
REQ-020 Push in IDLE (push=1, pop=0, full=0) SHALL drive mem_write=1, mem_addr=sp and mem_din=push_data combinationally in the same cycle, with sp<=sp+1 at the edge.
REQ-021 Pop in IDLE (pop=1, push=0, empty=0) SHALL drive mem_write=0 and mem_addr=sp-1 in the same cycle, with sp<=sp-1 and state<=RD_WAIT at the edge.
REQ-022 In RD_WAIT the block SHALL load pop_data<=mem_dout, return to IDLE, and assert pop_valid in the following cycle; pop latency from acceptance to pop_valid is 2 cycles.
REQ-023 Back-to-back pushes SHALL sustain 1 per cycle; pops SHALL sustain 1 per 2 cycles.
REQ-024 When no access is issued (IDLE without a valid operation, or in RD_WAIT), the block SHALL drive mem_write=0, mem_addr=0 and mem_din=0.
REQ-025 Push when full SHALL produce no write, leave sp unchanged, and set err_ovf.
REQ-026 Pop when empty SHALL produce no read and no pop_valid, leave sp unchanged, and set err_unf.
REQ-027 push=1 and pop=1 together in IDLE SHALL perform neither operation, leave sp unchanged, and set err_col; this has precedence over REQ-025/026.
REQ-028 flush=1 SHALL set sp<=0 and state<=IDLE, abort any pending pop (no pop_valid in the next cycle), suppress any push/pop in that cycle (mem_write=0), and leave pop_data unchanged.
REQ-029 clear_err=1 SHALL clear all sticky flags; an error event in the same cycle SHALL win, leaving its flag set.
REQ-030 sp SHALL never leave the range 0..DEPTH, and mem_addr SHALL never reach DEPTH or above.
REQ-031 RAM contents SHALL not be cleared by flush; stale data above sp is never read.

Reset
REQ-032 On rst_n=0 the block SHALL immediately and asynchronously set: state=IDLE, sp=0, pop_data=0x00, pop_valid=0, all error flags=0, and therefore ready=1, empty=1, full=0, depth=0, mem_write=0.
REQ-033 Reset asserted in RD_WAIT SHALL discard the pending pop, with no pop_valid after release.

Verification
REQ-034 Reset -> depth=0, empty=1, full=0, ready=1, pop_valid=0, err_*=0, mem_write=0.
REQ-035 Push 0x11, 0x22, 0x33 on consecutive cycles -> mem_write=1 at addresses 0, 1, 2 and depth=3; three pops -> pop_valid 2 cycles after each acceptance with 0x33, 0x22, 0x11, then empty=1.
REQ-036 64 pushes (DEPTH=64) -> full=1; a 65th push -> mem_write=0, depth=64, err_ovf=1; clear_err -> err_ovf=0.
REQ-037 Pop at depth=0 -> no pop_valid, err_unf=1, depth=0; the next push -> writes address 0.
REQ-038 At depth=5, push=1 and pop=1 in the same cycle -> mem_write=0, depth=5, err_col=1, no pop_valid.
REQ-039 At depth=3, pop accepted, then flush in RD_WAIT -> no pop_valid, depth=0, ready=1; the next push writes address 0.
